// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the core load/store port and a DMA master.
// Build option: define ARB_RR_EN for round-robin conflict resolution instead of core priority.
module data_ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iCore_Req,
    input  logic              iCore_WrEn,
    input  logic [2:0]        iCore_Funct3,
    input  logic [ADDR_W-1:0] iCore_Addr,
    input  logic [DATA_W-1:0] iCore_WrData,
    output logic [DATA_W-1:0] oCore_RdData,
    output logic              oCore_Stall,
    input  logic              iDma_Req,
    input  logic              iDma_WrEn,
    input  logic [ADDR_W-1:0] iDma_Addr,
    input  logic [DATA_W-1:0] iDma_WrData,
    input  logic              iDma_Last,
    output logic              oDma_Gnt,
    output logic [DATA_W-1:0] oDma_RdData,
    output logic              oDma_RdValid,
    output logic              oRam_WrEn,
    output logic [2:0]        oRam_Funct3,
    output logic [ADDR_W-1:0] oRam_Addr,
    output logic [DATA_W-1:0] oRam_WrData,
    input  logic [DATA_W-1:0] iRam_RdData
);
    localparam logic [0:0] CORE_PRI = 1'b0;
    localparam logic [0:0] DMA_OWN  = 1'b1;
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [0:0]      rState;
    logic [BC_W-1:0] rBeatCnt;
    logic            rDmaRdValid;
    logic [DATA_W-1:0] rDmaRdData;
    logic            w_dma_gnt;
    logic            w_core_gnt;
    logic            w_dma_sel;
    logic            w_core_sel;

`ifdef ARB_RR_EN
    // Set after a core grant so the next conflict goes to DMA; reset leaves core first.
    logic rLastDma;
`else
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    logic [WC_W-1:0] rWaitCnt;
`endif

    always_comb begin
        w_dma_gnt  = 1'b0;
        w_core_gnt = 1'b0;
        if (rState == DMA_OWN) begin
            w_dma_gnt  = iDma_Req;
            w_core_gnt = iCore_Req && !iDma_Req;
        end else begin
`ifdef ARB_RR_EN
            w_dma_gnt  = iDma_Req && (!iCore_Req || rLastDma);
`else
            w_dma_gnt  = iDma_Req && (!iCore_Req || rWaitCnt == WC_W'(MAX_WAIT));
`endif
            w_core_gnt = iCore_Req && !w_dma_gnt;
        end
    end

    // Reset must silence the bus immediately, not at the next edge.
    assign w_dma_sel  = iRst_n && w_dma_gnt;
    assign w_core_sel = iRst_n && w_core_gnt;

    always_comb begin
        oRam_WrEn   = 1'b0;
        oRam_Funct3 = 3'b000;
        oRam_Addr   = '0;
        oRam_WrData = '0;
        if (w_core_sel) begin
            oRam_WrEn   = iCore_WrEn;
            oRam_Funct3 = iCore_Funct3;
            oRam_Addr   = iCore_Addr;
            oRam_WrData = iCore_WrData;
        end else if (w_dma_sel) begin
            oRam_WrEn   = iDma_WrEn;
            oRam_Funct3 = 3'b010;
            oRam_Addr   = iDma_Addr;
            oRam_WrData = iDma_WrData;
        end
    end

    assign oCore_RdData = iRam_RdData;
    assign oCore_Stall  = iRst_n && iCore_Req && !w_core_gnt;
    assign oDma_Gnt     = w_dma_sel;
    assign oDma_RdData  = rDmaRdData;
    assign oDma_RdValid = rDmaRdValid;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rState      <= CORE_PRI;
            rBeatCnt    <= '0;
            rDmaRdValid <= 1'b0;
            rDmaRdData  <= '0;
`ifdef ARB_RR_EN
            rLastDma    <= 1'b0;
`else
            rWaitCnt    <= '0;
`endif
        end else begin
            rDmaRdValid <= w_dma_gnt && !iDma_WrEn;
            if (w_dma_gnt && !iDma_WrEn)
                rDmaRdData <= iRam_RdData;

            case (rState)
                CORE_PRI: begin
                    if (w_dma_gnt && !iDma_Last && (MAX_BURST > 1)) begin
                        rState   <= DMA_OWN;
                        rBeatCnt <= BC_W'(1);
                    end
                end
                DMA_OWN: begin
                    if (!iDma_Req || iDma_Last || rBeatCnt == BC_W'(MAX_BURST - 1)) begin
                        rState   <= CORE_PRI;
                        rBeatCnt <= '0;
                    end else begin
                        rBeatCnt <= rBeatCnt + BC_W'(1);
                    end
                end
                default: begin
                    rState   <= CORE_PRI;
                    rBeatCnt <= '0;
                end
            endcase

`ifdef ARB_RR_EN
            if (w_core_gnt)
                rLastDma <= 1'b1;
            else if (w_dma_gnt)
                rLastDma <= 1'b0;
`else
            if (!iDma_Req || w_dma_gnt)
                rWaitCnt <= '0;
            else if (rWaitCnt != WC_W'(MAX_WAIT))
                rWaitCnt <= rWaitCnt + WC_W'(1);
`endif
        end
    end
endmodule
